// File: rtl/fft_frame_packer_pkg.sv
// fft_pkg: shared FFT front-end defaults, complex sample type and counter-width helper.
package fft_pkg;
  localparam int FFT_SIZE_DEFAULT = 1024;
  localparam int DATA_WIDTH_DEFAULT = 16;
  typedef struct packed {
    logic [DATA_WIDTH_DEFAULT-1:0] imag;
    logic [DATA_WIDTH_DEFAULT-1:0] re;
  } fft_cplx_t;
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fft_frame_packer_if.sv
// fft_frame_packer_if: AXI-stream data channel toward the FFT core's s_axis_data port.
interface fft_frame_packer_if #(parameter int DATA_WIDTH = 16);
  logic [2*DATA_WIDTH-1:0] tdata;
  logic tvalid;
  logic tlast;
  logic tready;
  modport master(output tdata, tvalid, tlast, input tready);
  modport slave(input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/fft_frame_packer_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with registered occupancy count.
module sync_fifo
  import fft_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = cnt_width(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  // Flags come from the registered count, so a full FIFO refuses a push even when a pop happens that cycle.
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/fft_frame_packer.sv
// fft_frame_packer: decimates, buffers and frames signed audio samples into complex AXI-stream beats.
module fft_frame_packer
  import fft_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 8,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int FFT_SIZE = FFT_SIZE_DEFAULT,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    sample_valid_in,
  input  logic [3:0]              decim_in,
  fft_frame_packer_if.master      m_axis,
  output logic                    overflow_out,
  output logic [15:0]             frame_count_out
);
  localparam int BW = cnt_width(FFT_SIZE);
  logic [3:0] dcnt;
  logic [BW-1:0] beat;
  logic keep, wrap, full, empty, xfer;
  logic signed [DATA_WIDTH-1:0] ext;
  logic [DATA_WIDTH-1:0] re, head;
  assign wrap = decim_in <= 4'd1 || dcnt >= decim_in - 4'd1;
  assign keep = sample_valid_in && (decim_in <= 4'd1 || dcnt == '0);
  assign ext = DATA_WIDTH'(signed'(sample_in));
  assign re = ext << (DATA_WIDTH - SAMPLE_WIDTH);
  sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk_in),
    .rst(rst_in),
    .push(keep),
    .din(re),
    .pop(xfer),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  assign m_axis.tvalid = !empty;
  assign m_axis.tdata = {{DATA_WIDTH{1'b0}}, head};
  assign m_axis.tlast = !empty && beat == BW'(FFT_SIZE - 1);
  assign xfer = m_axis.tvalid && m_axis.tready;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      dcnt <= '0;
      beat <= '0;
      frame_count_out <= '0;
      overflow_out <= 1'b0;
    end else begin
      if (sample_valid_in) dcnt <= wrap ? '0 : dcnt + 4'd1;
      if (keep && full) overflow_out <= 1'b1;
      if (xfer) begin
        beat <= m_axis.tlast ? '0 : beat + 1'b1;
        if (m_axis.tlast) frame_count_out <= frame_count_out + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_fft_frame_packer.sv
// tb_fft_frame_packer: directed and randomized checks against a queue-based reference model.
module tb_fft_frame_packer;
  import fft_pkg::*;
  localparam int SW = 8;
  localparam int DW = 16;
  localparam int FS = 8;
  localparam int FD = 16;
  logic clk = 1'b0;
  logic rst;
  logic [SW-1:0] sample;
  logic sv;
  logic [3:0] decim;
  logic ovf;
  logic [15:0] fc;
  fft_frame_packer_if #(.DATA_WIDTH(DW)) m_axis();
  fft_frame_packer #(.SAMPLE_WIDTH(SW), .DATA_WIDTH(DW), .FFT_SIZE(FS), .FIFO_DEPTH(FD)) dut (
    .clk_in(clk),
    .rst_in(rst),
    .sample_in(sample),
    .sample_valid_in(sv),
    .decim_in(decim),
    .m_axis(m_axis),
    .overflow_out(ovf),
    .frame_count_out(fc)
  );
  always #5 clk = ~clk;
  logic [15:0] q[$];
  logic [15:0] got[$];
  int xfers, since, dut_xfers, dut_lasts;
  bit m_ovf;
  int vectors = 0;
  int miscompares = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic check_outputs();
    fft_cplx_t e;
    logic ev;
    ev = q.size() > 0;
    e.imag = '0;
    e.re = ev ? q[0] : 16'h0;
    chk("tvalid", m_axis.tvalid, ev);
    chk("tdata", m_axis.tdata, e);
    chk("tlast", m_axis.tlast, ev && (xfers % FS == FS - 1));
    chk("overflow", ovf, m_ovf);
    chk("frames", fc, (xfers / FS) & 16'hFFFF);
  endtask
  task automatic tick(input bit v, input logic [SW-1:0] s, input bit r);
    bit keep, is_full, pop;
    sv = v;
    sample = s;
    m_axis.tready = r;
    check_outputs();
    if (m_axis.tvalid && r) begin
      dut_xfers++;
      if (m_axis.tlast) dut_lasts++;
      got.push_back(m_axis.tdata[15:0]);
    end
    keep = v && (decim <= 1 || since >= decim);
    if (v) since = keep ? 1 : (since < 15 ? since + 1 : 15);
    is_full = q.size() == FD;
    pop = q.size() > 0 && r;
    if (keep && is_full) m_ovf = 1;
    if (pop) begin
      void'(q.pop_front());
      xfers++;
    end
    if (keep && !is_full) q.push_back(16'($signed(s) * 256));
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    sv = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    got.delete();
    xfers = 0;
    since = 15;
    m_ovf = 0;
    dut_xfers = 0;
    dut_lasts = 0;
    check_outputs();
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 100) begin
      tick(0, '0, 1);
      n++;
    end
    tick(0, '0, 1);
  endtask
  initial begin
    rst = 1'b1;
    sv = 1'b0;
    sample = '0;
    decim = 4'd1;
    m_axis.tready = 1'b0;
    do_reset();
    // bring-up: 16 samples, continuous ready
    for (int i = 1; i <= 16; i++) tick(1, SW'(i), 1);
    drain();
    chk("bringup_frames", fc, 16'd2);
    chk("bringup_lasts", dut_lasts, 2);
    chk("bringup_beats", dut_xfers, 16);
    // sign extension
    do_reset();
    tick(1, 8'h80, 0);
    chk("sign_80", m_axis.tdata, 32'h0000_8000);
    tick(0, '0, 1);
    tick(1, 8'hFF, 0);
    chk("sign_ff", m_axis.tdata, 32'h0000_FF00);
    drain();
    // backpressure: ready toggles every cycle
    do_reset();
    for (int i = 0; i < 24; i++) tick(1, SW'($urandom), i[0] == 1'b0);
    for (int i = 0; i < 60 && q.size() > 0; i++) tick(0, '0, i[0] == 1'b0);
    drain();
    chk("bp_beats", dut_xfers, 24);
    chk("bp_lasts", dut_lasts, 3);
    // overflow: 17 samples into a 16-deep FIFO
    do_reset();
    for (int i = 0; i < 17; i++) tick(1, SW'($urandom), 0);
    chk("ovf_set", ovf, 1'b1);
    drain();
    chk("ovf_drain", dut_xfers, 16);
    chk("ovf_lasts", dut_lasts, 2);
    chk("ovf_sticky", ovf, 1'b1);
    // decimation by 3, then keep-all
    do_reset();
    decim = 4'd3;
    for (int i = 0; i < 24; i++) tick(1, SW'(i), 1);
    drain();
    chk("decim_count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) chk("decim_val", got[i], 16'(3 * i * 256));
    got.delete();
    decim = 4'd0;
    for (int i = 24; i < 48; i++) tick(1, SW'(i), 1);
    drain();
    chk("d0_count", got.size(), 24);
    decim = 4'd1;
    // reset mid-frame after beat 5
    do_reset();
    for (int i = 0; i < 5; i++) tick(1, SW'(i + 1), 1);
    drain();
    for (int i = 0; i < 3; i++) tick(1, SW'($urandom), 0);
    do_reset();
    chk("rst_tvalid", m_axis.tvalid, 1'b0);
    chk("rst_tdata", m_axis.tdata, 32'h0);
    for (int i = 0; i < 8; i++) tick(1, SW'($urandom), 1);
    drain();
    chk("rst_frames", fc, 16'd1);
    chk("rst_lasts", dut_lasts, 1);
    // random segments with a fixed decimation factor each
    for (int k = 0; k < 4; k++) begin
      do_reset();
      decim = 4'($urandom_range(0, 5));
      for (int i = 0; i < 200; i++) tick($urandom_range(0, 9) < 7, SW'($urandom), $urandom_range(0, 3) != 0);
      drain();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fft_frame_packer.md
# fft_frame_packer

Parametrised front end for the Xilinx FFT core. It takes a stream of signed audio samples, optionally decimates them and buffers them in a small FIFO. It sign-extends and left-justifies each sample into a complex AXI-stream word with zero imaginary part, and asserts tlast on exactly every FFT_SIZE-th beat. It sits between the audio capture path and the FFT core's s_axis_data port, and it replaces ad-hoc tvalid/tlast driving with a backpressure-correct, frame-aligned source.

## Interface
- SAMPLE_WIDTH, 8: width of the signed input sample.
- DATA_WIDTH, 16: width of each FFT component. tdata is 2*DATA_WIDTH; must be ≥ SAMPLE_WIDTH.
- FFT_SIZE, 1024: points per frame. Must be a power of two, ≥ 8.
- FIFO_DEPTH, 16: sample buffer entries. Must be a power of two, ≥ 2.
- clk_in  input  1  system clock (100 MHz); all logic on its rising edge.
- rst_in  input  1  synchronous, active-high reset.
- sample_in  input  SAMPLE_WIDTH  signed audio sample.
- sample_valid_in  input  1  single-cycle strobe; sample_in is valid this cycle.
- decim_in  input  4  decimation factor D. Values 0 and 1 mean keep every sample.
- m_axis_tdata  output  2*DATA_WIDTH  {imag[DATA_WIDTH-1:0]=0, real[DATA_WIDTH-1:0]}.
- m_axis_tvalid  output  1  beat available.
- m_axis_tlast  output  1  last beat of a frame.
- m_axis_tready  input  1  FFT core ready.
- overflow_out  output  1  sticky: a kept sample was dropped because the FIFO was full.
- frame_count_out  output  16  completed frames, wraps 0xFFFF→0.

## Operation
- Decimator: a counter counts strobes 0..D-1. A strobe is kept when the counter is 0, and the counter then wraps to 0 after D-1.
  - decim_in is applied live. If the counter is ≥ D-1 at a strobe, it resets to 0.
  - D ≤ 1 keeps every strobe.
- Formatting of a kept sample: real = sample_in << (DATA_WIDTH-SAMPLE_WIDTH), with the sign preserved. imag = 0.
- FIFO push happens when a kept sample arrives and the FIFO is not full.
  - If the FIFO is full, the sample is dropped and overflow_out is set to 1. overflow_out stays 1 until reset.
  - The full flag uses the registered count, so push while full is refused even if a pop occurs that cycle.
- Output handshake (AXI-stream):
  - m_axis_tvalid = FIFO not empty.
  - A beat transfers when tvalid && tready.
  - tdata and tlast are stable while tvalid is high and tready is low.
  - tvalid never drops without a transfer, except on reset.
- Beat counter: counts 0..FFT_SIZE-1, incrementing on each transfer.
  - m_axis_tlast = tvalid && (beat == FFT_SIZE-1).
  - On a tlast transfer, beat returns to 0 and frame_count_out increments.
- Dropped samples never disturb framing. tlast always falls on every FFT_SIZE-th transferred beat.

## Timing
- Values after reset (cycle after rst_in sampled high):
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
  - overflow_out=0, frame_count_out=0.
  - FIFO empty; beat counter and decimation counter both 0.
- Reset mid-frame discards the partial frame and all buffered samples. The next frame starts at beat 0.
- Latency: a sample kept at edge t, with the FIFO empty, gives m_axis_tvalid=1 in the cycle after edge t. It can transfer at edge t+1.
- Throughput: one beat per cycle when tready is continuously high.
- Push and pop in the same cycle:
  - If not full, both occur and the count is unchanged.
  - If empty, there is no pop; the pushed sample appears next cycle.
- With tready=0, the FIFO fills after FIFO_DEPTH kept samples. The next kept sample sets overflow_out at the following edge.

## Structure
- Package fft_pkg holds:
  - default constants: FFT_SIZE_DEFAULT=1024, DATA_WIDTH_DEFAULT=16;
  - typedef fft_cplx_t, a packed struct {imag, real} of DATA_WIDTH_DEFAULT each;
  - the log2 width helper for the beat counter.
- Sub-module: sync_fifo (parametrised WIDTH, DEPTH), with registered count and full/empty flags and first-word-fall-through output. It is reused by later FFT-output buffering.
- Top level holds the decimator, formatter, beat/frame counters and overflow flag.

## Test plan
- Bring-up: FFT_SIZE=8, D=1, tready=1. Feed samples 1..16 on consecutive cycles.
  - Real parts 0x0100..0x1000 appear, imag=0.
  - tlast on beats 8 and 16; frame_count_out=2.
- Sign: sample 0x80 → tdata=0x0000_8000; sample 0xFF → 0x0000_FF00.
- Backpressure: tready toggles 1/0 each cycle.
  - No beat is lost or duplicated.
  - tdata/tlast hold while tready=0.
  - tlast lands only on the 8th transferred beat.
- Overflow: tready=0, push 17 samples with FIFO_DEPTH=16.
  - overflow_out=1 after the 17th sample.
  - After tready=1, exactly 16 beats drain; tlast is on beats 8 and 16.
- Decimation: D=3 with strobes carrying values 0..23 → only 0,3,6,…,21 are emitted. Then set D=0 → every sample is emitted.
- Reset mid-frame: assert rst_in after beat 5 of a frame.
  - All outputs are 0 the next cycle.
  - The following 8 beats end with tlast on beat 8.
